// File: rtl/ws281x_pkg.sv
// ws281x_pkg -- shared state encoding, width helper, timing-constant
// derivation and the brightness scaling helper for the WS281x streamer.
package ws281x_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_BIT   = 2'd2,
    ST_LATCH = 2'd3
  } state_e;

  // Ceiling log2; 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((32'sd1 <<< r) < value) begin
      r = r + 32'sd1;
    end
    return r;
  endfunction

  // Counter width that never collapses to zero bits.
  function automatic int cnt_width(input int n);
    return (clog2(n) < 32'sd1) ? 32'sd1 : clog2(n);
  endfunction

  // Clock cycles per serial bit.
  function automatic int calc_cyc(input int sys_clk, input int bit_rate);
    return sys_clk / bit_rate;
  endfunction

  // High time in cycles for a given percentage of the bit period.
  function automatic int calc_high(input int cyc, input int pct);
    return (cyc * pct) / 32'sd100;
  endfunction

  // Latch (reset) low time in cycles.
  function automatic int calc_rst(input int reset_us, input int sys_clk);
    return reset_us * (sys_clk / 32'sd1_000_000);
  endfunction

  // Byte scaled by brightness b: (c*(b+1))>>8, so b=255 is identity.
  function automatic logic [7:0] scale_byte(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] prod;
    prod = {8'd0, c} * ({8'd0, b} + 16'd1);
    return prod[15:8];
  endfunction

endpackage

// File: rtl/ws281x_bit_encoder.sv
// ws281x_bit_encoder -- produces one WS281x bit waveform of CYC cycles:
// high for T0H (bit 0) or T1H (bit 1) cycles, then low. A start pulse in
// the cycle where done is high chains the next bit with no gap.
module ws281x_bit_encoder
  import ws281x_pkg::*;
#(
  parameter int CYC = 25,
  parameter int T0H = 8,
  parameter int T1H = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start_i,
  input  logic bit_i,
  output logic do_o,
  output logic done_o
);

  localparam int CW = cnt_width(CYC + 1);
  localparam logic [CW-1:0] LAST_C = CW'(CYC - 1);
  localparam logic [CW-1:0] T0H_C  = CW'(T0H);
  localparam logic [CW-1:0] T1H_C  = CW'(T1H);

  logic          active_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] th_q;
  logic          do_q;
  logic [CW-1:0] th_s;

  assign th_s   = bit_i ? T1H_C : T0H_C;
  assign do_o   = do_q;
  assign done_o = active_q && (cnt_q == LAST_C);

  // Bit-period counter with registered line output (high while cnt < high time)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      th_q     <= '0;
      do_q     <= 1'b0;
    end else if (start_i) begin
      active_q <= 1'b1;
      cnt_q    <= '0;
      th_q     <= th_s;
      do_q     <= (th_s != '0);
    end else if (active_q) begin
      if (cnt_q == LAST_C) begin
        active_q <= 1'b0;
        cnt_q    <= '0;
        do_q     <= 1'b0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
        do_q  <= ((cnt_q + CW'(1)) < th_q);
      end
    end else begin
      do_q <= 1'b0;
    end
  end

endmodule

// File: rtl/ws281x_stream.sv
// ws281x_stream -- frames NUM_LEDS pixels from a valid/ready stream onto a
// WS281x serial line, followed by a latch low period.
// Optional feature: define WS281X_BRIGHTNESS_EN to scale every byte by the
// brightness value sampled when the frame is accepted.
module ws281x_stream
  import ws281x_pkg::*;
#(
  parameter int NUM_LEDS     = 4,
  parameter int SYSTEM_CLOCK = 100_000_000,
  parameter int CHANNELS     = 3,
  parameter int BIT_RATE     = 800_000,
  parameter int T0H_PCT      = 32,
  parameter int T1H_PCT      = 64,
  parameter int RESET_US     = 80
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              frame_start,
  input  logic                              pix_valid,
  output logic                              pix_ready,
  input  logic [CHANNELS*8-1:0]             pix_data,
  input  logic [7:0]                        brightness,
  output logic [cnt_width(NUM_LEDS)-1:0]    address,
  output logic                              busy,
  output logic                              underrun,
  output logic                              DO
);

  localparam int W   = CHANNELS * 8;
  localparam int CYC = calc_cyc(SYSTEM_CLOCK, BIT_RATE);
  localparam int T0H = calc_high(CYC, T0H_PCT);
  localparam int T1H = calc_high(CYC, T1H_PCT);
  localparam int RST = calc_rst(RESET_US, SYSTEM_CLOCK);
  localparam int AW  = cnt_width(NUM_LEDS);
  localparam int BW  = cnt_width(W);
  localparam int LW  = cnt_width(RST);

  localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_LEDS - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(W - 1);
  localparam logic [LW-1:0] RST_LAST  = LW'(RST - 1);

  state_e        state_q;
  logic [AW-1:0] addr_q;
  logic          underrun_q;
  logic [W-1:0]  shift_q;
  logic [BW-1:0] bit_cnt_q;
  logic [LW-1:0] lat_cnt_q;

  logic [W-1:0]  scaled_s;
  logic          last_bit_s;
  logic          enc_start_s;
  logic          enc_bit_s;
  logic          enc_done_s;

  assign pix_ready  = (state_q == ST_LOAD);
  assign busy       = (state_q != ST_IDLE);
  assign address    = addr_q;
  assign underrun   = underrun_q;
  assign last_bit_s = (bit_cnt_q == LAST_BIT);

`ifdef WS281X_BRIGHTNESS_EN
  logic [7:0] bright_q;

  // Scale every incoming byte by the brightness latched at frame start
  always_comb begin
    scaled_s = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      scaled_s[i*8 +: 8] = scale_byte(pix_data[i*8 +: 8], bright_q);
    end
  end
`else
  logic unused_bright_s;
  assign unused_bright_s = ^brightness;

  // Bytes go out exactly as captured
  always_comb begin
    scaled_s = pix_data;
  end
`endif

  // Kick the bit encoder on pixel capture and on each non-final bit boundary
  always_comb begin
    enc_start_s = 1'b0;
    enc_bit_s   = 1'b0;
    if ((state_q == ST_LOAD) && pix_valid) begin
      enc_start_s = 1'b1;
      enc_bit_s   = scaled_s[W-1];
    end else if ((state_q == ST_BIT) && enc_done_s && !last_bit_s) begin
      enc_start_s = 1'b1;
      enc_bit_s   = shift_q[W-2];
    end else begin
      enc_start_s = 1'b0;
      enc_bit_s   = 1'b0;
    end
  end

  ws281x_bit_encoder #(
    .CYC (CYC),
    .T0H (T0H),
    .T1H (T1H)
  ) u_enc (
    .clk     (clk),
    .reset_n (reset_n),
    .start_i (enc_start_s),
    .bit_i   (enc_bit_s),
    .do_o    (DO),
    .done_o  (enc_done_s)
  );

  // Frame sequencer: idle, pixel load, bit streaming and latch low time
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      underrun_q <= 1'b0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      lat_cnt_q  <= '0;
`ifdef WS281X_BRIGHTNESS_EN
      bright_q   <= 8'd0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (frame_start) begin
            state_q    <= ST_LOAD;
            addr_q     <= '0;
            underrun_q <= 1'b0;
`ifdef WS281X_BRIGHTNESS_EN
            bright_q   <= brightness;
`endif
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (pix_valid) begin
            shift_q   <= scaled_s;
            bit_cnt_q <= '0;
            state_q   <= ST_BIT;
          end else if (addr_q != '0) begin
            // Stream fell behind mid-frame: abort and latch what was sent
            underrun_q <= 1'b1;
            lat_cnt_q  <= '0;
            state_q    <= ST_LATCH;
          end else begin
            state_q <= ST_LOAD;
          end
        end
        ST_BIT: begin
          if (enc_done_s) begin
            if (!last_bit_s) begin
              shift_q   <= {shift_q[W-2:0], 1'b0};
              bit_cnt_q <= bit_cnt_q + BW'(1);
            end else begin
              bit_cnt_q <= '0;
              if (addr_q < LAST_ADDR) begin
                addr_q  <= addr_q + AW'(1);
                state_q <= ST_LOAD;
              end else begin
                lat_cnt_q <= '0;
                state_q   <= ST_LATCH;
              end
            end
          end else begin
            state_q <= ST_BIT;
          end
        end
        ST_LATCH: begin
          if (lat_cnt_q == RST_LAST) begin
            lat_cnt_q <= '0;
            state_q   <= ST_IDLE;
          end else begin
            lat_cnt_q <= lat_cnt_q + LW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ws281x_stream.md
WS281X_STREAM -- requirements
Module: ws281x_stream

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 4, meaning pixels per frame (>=1).
REQ-002 SHALL have parameter SYSTEM_CLOCK, default 100_000_000, meaning clk frequency in Hz.
REQ-003 SHALL have parameter CHANNELS, default 3, meaning bytes per pixel (3 = RGB, 4 = RGBW; other values are illegal).
REQ-004 SHALL have parameter BIT_RATE, default 800_000, meaning serial bit rate in Hz.
REQ-005 SHALL have parameters T0H_PCT and T1H_PCT, defaults 32 and 64, meaning high time of a 0 bit and a 1 bit as a percentage of the bit period.
REQ-006 SHALL have parameter RESET_US, default 80, meaning latch low time in microseconds.
REQ-007 SHALL have port clk, input, 1 bit, the single clock; one clock; reset is asynchronous and active-low.
REQ-008 SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-009 SHALL have port frame_start, input, 1 bit, a pulse that requests a frame.
REQ-010 SHALL have ports pix_valid (input, 1), pix_ready (output, 1) and pix_data (input, CHANNELS*8), where pix_data is in wire order with MSB sent first.
REQ-011 SHALL have port brightness, input, 8 bits, global scale factor.
REQ-012 SHALL have ports address (output, clog2(NUM_LEDS) bits, index of the pixel in flight), busy (output, 1), underrun (output, 1, sticky) and DO (output, 1, serial line).

Function
REQ-013 SHALL derive constants: CYC = SYSTEM_CLOCK/BIT_RATE, T0H = CYC*T0H_PCT/100, T1H = CYC*T1H_PCT/100, RST = RESET_US*(SYSTEM_CLOCK/1_000_000), all using integer truncation.
REQ-014 SHALL implement states IDLE, LOAD, BIT and LATCH.
REQ-015 IDLE: DO=0, busy=0; frame_start=1 moves to LOAD next cycle, sets address=0, clears underrun and samples brightness for the frame.
REQ-016 SHALL ignore frame_start outside IDLE.
REQ-017 LOAD: pix_ready=1 combinationally and only in this state; pix_valid=1 captures pix_data, moves to BIT, and DO rises on the next cycle.
REQ-018 LOAD at address 0: SHALL wait indefinitely for pix_valid with DO=0.
REQ-019 LOAD at address>0: pix_valid=0 SHALL set underrun, abort the frame and enter LATCH.
REQ-020 BIT: each bit SHALL last exactly CYC cycles, with DO=1 for the first T0H (bit=0) or T1H (bit=1) cycles and DO=0 for the remainder; bits are sent MSB first, CHANNELS*8 bits per pixel.
REQ-021 After the last bit of a pixel: if address<NUM_LEDS-1, SHALL increment address and go to LOAD; otherwise go to LATCH.
REQ-022 LATCH: DO=0 for exactly RST cycles, then IDLE; busy=1 in LOAD, BIT and LATCH.
REQ-023 address SHALL never exceed NUM_LEDS-1 and SHALL not wrap within a frame.
REQ-024 underrun SHALL hold until the next accepted frame_start or reset.

Reset
REQ-025 reset_n=0 SHALL asynchronously force state=IDLE, DO=0, pix_ready=0, busy=0, address=0, underrun=0 and all counters to 0, including mid-bit or mid-latch.
REQ-026 The first frame after reset SHALL be accepted without a preceding LATCH.

Configuration
REQ-027 With macro WS281X_BRIGHTNESS_EN defined, each captured byte c SHALL be sent as (c*(B+1))>>8, where B is the brightness sampled at frame start; B=255 is identity.
REQ-028 Without WS281X_BRIGHTNESS_EN, brightness SHALL be ignored, bytes SHALL be sent unmodified, and no multiplier SHALL be present.

Structure
REQ-029 Package ws281x_pkg SHALL hold the state encoding, the clog2 function and the timing-constant derivation functions.
REQ-030 Sub-module ws281x_bit_encoder (inputs start and bit; outputs DO and done; parameters CYC, T0H and T1H) SHALL generate one bit waveform; the top level SHALL own the FSM, the shift register and the scaling.

Verification (SYSTEM_CLOCK=20 MHz: CYC=25, T0H=8, T1H=16, RST=1600)
REQ-031 Single pixel: NUM_LEDS=1, CHANNELS=3, pix_data=0x800001 -> first bit high 16 cycles, next 22 bits high 8 cycles, last bit high 16 cycles, each bit 25 cycles, then 1600 low cycles, busy falls.
REQ-032 RGBW: CHANNELS=4, NUM_LEDS=2, pixels 0xFFFFFFFF and 0x00000000 -> 32 bits of 16-high followed by 32 bits of 8-high; address goes 0 then 1; pix_ready pulses exactly twice.
REQ-033 Underrun: NUM_LEDS=3, pix_valid drops before pixel 1 -> underrun=1, DO low for 1600 cycles, then IDLE; the next frame_start clears underrun.
REQ-034 Reset mid-bit: reset_n=0 during a DO-high phase -> DO=0 in the same cycle, busy=0; after release, frame_start starts a clean frame.
REQ-035 Brightness (macro on): B=127, byte 0xFF -> 0x7F sent; B=255 -> 0xFF; brightness changed mid-frame has no effect until the next frame. Macro off: B=0, byte 0xFF -> 0xFF sent.
REQ-036 frame_start held high through an entire frame -> exactly one frame per IDLE entry; no restart while busy=1.
